seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the 8-bit datapath ALU. It takes one operation per transaction on a valid/ready input, produces a registered result plus Z/N/C/V flags on a valid/ready output, and adds XOR, shifts and a multi-cycle shift-add multiply. It sits between the register-file read ports and the writeback/flags register in the CPU datapath.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width; power of two, ≥ 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width; derived, not overridden.

Clock and reset: one clock; reset is asynchronous and active-low.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `op`  in  3  opcode:
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B; for shifts, `b[SHW-1:0]` is the amount.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  registered result.
- `zero`, `negative`, `carry`, `overflow`  out  1 each  registered flags.

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - `in_ready`=1. Accept on `in_valid && in_ready`; latch `op`, `a`, `b`.
  - Non-MUL ops: compute, register result and flags, go to DONE.
  - MUL: clear the accumulator and counter, go to MUL.
- MUL:
  - One multiplier bit per cycle, LSB first; `acc += (b_sh[0] ? a_sh : 0)`, with `a_sh` shifted left and `b_sh` shifted right each cycle.
  - Accumulator is 2*WIDTH bits.
  - After WIDTH iterations go to DONE with `result` = `acc[WIDTH-1:0]`.
- DONE:
  - `out_valid`=1; `result` and flags held stable.
  - On `out_ready` go to IDLE.
  - `in_valid` is ignored; no overlap of transactions.
- Arithmetic is modulo 2^WIDTH. Operands are unsigned, except V, which treats them as two's complement.
- Flags:
  - Z = (`result`==0) for all ops.
  - N = `result[WIDTH-1]` for all ops.
  - C:
    - ADD: carry-out.
    - SUB: borrow, i.e. a<b unsigned.
    - SHL/SHR: last bit shifted out; amount 0 gives C=0.
    - MUL: `acc[2*WIDTH-1:WIDTH]` != 0.
    - Logic ops: C=0.
  - V:
    - ADD: signed overflow, i.e. operands share a sign and the result sign differs.
    - SUB: signed overflow, i.e. operand signs differ and the result sign differs from a.
    - All other ops: V=0.
- Shift amount is `b[SHW-1:0]`; upper bits of `b` are ignored.

## Timing
- Reset: state=IDLE, `result`=0, all flags 0, `out_valid`=0, accumulator and counter 0; `in_ready`=1 once in IDLE.
- Reset asserted mid-MUL or in DONE: transaction aborted, no output produced.
- Latency, measured from the accepting edge k:
  - Non-MUL ops: `out_valid` high after edge k+1.
  - MUL: `out_valid` high after edge k+WIDTH+1.
- `out_valid` stays high until the edge where `out_ready`=1; it falls after that edge and `in_ready` rises.
- Throughput: non-MUL, one op per 2 cycles with `out_ready` tied high; MUL, one op per WIDTH+2 cycles.
- `in_ready` and `out_valid` are pure decodes of the state register. No combinational path from `in_valid` or `out_ready` to either.

## Test plan
All scenarios use WIDTH=8.
1. ADD, a=0xFF, b=0x01, `out_ready`=1:
   - `result`=0x00, Z=1, C=1, V=0, N=0.
   - `out_valid` exactly 1 cycle after acceptance.
2. SUB:
   - 0x80−0x01 gives 0x7F, V=1, C=0, N=0.
   - 0x03−0x05 gives 0xFE, C=1, N=1, V=0.
3. MUL:
   - 0x0F×0x11 gives 0xFF, C=0; `out_valid` 9 cycles after acceptance and `in_ready`=0 throughout.
   - 0x10×0x10 gives 0x00, Z=1, C=1.
4. Shifts:
   - SHL a=0x81, b=0x09 (amount 1) gives 0x02, C=1.
   - SHR a=0x01, b=0x00 gives 0x01, C=0.
   - SHR a=0x01, b=0x01 gives 0x00, Z=1, C=1.
5. Backpressure: XOR 0xAA^0x55 with `out_ready`=0 for 5 cycles while `in_valid`=1 with a different op.
   - `result`=0xFF held stable and `in_ready`=0 throughout.
   - Second op accepted only after the `out_ready` handshake plus one cycle.
6. Reset: `rst_n` low at the 3rd cycle of a MUL.
   - `out_valid`=0, `result`=0 and flags 0 immediately.
   - After release, `in_ready`=1 and a fresh ADD 0x01+0x02 gives 0x03.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic/shift ops and a
// shift-add multiply over WIDTH cycles, with registered result and Z/N/C/V flags.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     result_r;
    logic                 zero_r;
    logic                 negative_r;
    logic                 carry_r;
    logic                 overflow_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]     b_sh_r;
    logic [SHW-1:0]       cnt_r;

    logic [WIDTH-1:0]     alu_res_s;
    logic                 alu_c_s;
    logic                 alu_v_s;
    logic [WIDTH:0]       wide_s;
    logic [SHW-1:0]       shamt_s;
    logic [2*WIDTH-1:0]   acc_next_s;

    assign shamt_s    = b[SHW-1:0];
    assign acc_next_s = b_sh_r[0] ? (acc_r + a_sh_r) : acc_r;

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign result    = result_r;
    assign zero      = zero_r;
    assign negative  = negative_r;
    assign carry     = carry_r;
    assign overflow  = overflow_r;

    // Single-cycle datapath; the extra bit of wide_s carries carry/borrow or the shifted-out bit.
    always_comb begin
        wide_s    = {(WIDTH+1){1'b0}};
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (op)
            OP_ADD: begin
                wide_s    = {1'b0, a} + {1'b0, b};
                alu_res_s = wide_s[WIDTH-1:0];
                alu_c_s   = wide_s[WIDTH];
                alu_v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide_s    = {1'b0, a} - {1'b0, b};
                alu_res_s = wide_s[WIDTH-1:0];
                alu_c_s   = wide_s[WIDTH];
                alu_v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_XOR: alu_res_s = a ^ b;
            OP_SHL: begin
                wide_s    = {1'b0, a} << shamt_s;
                alu_res_s = wide_s[WIDTH-1:0];
                alu_c_s   = wide_s[WIDTH];
            end
            OP_SHR: begin
                wide_s    = {a, 1'b0} >> shamt_s;
                alu_res_s = wide_s[WIDTH:1];
                alu_c_s   = wide_s[0];
            end
            default: begin
                alu_res_s = {WIDTH{1'b0}};
                alu_c_s   = 1'b0;
                alu_v_s   = 1'b0;
            end
        endcase
    end

    // Control FSM with registered result/flags and the shift-add multiplier state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            result_r   <= {WIDTH{1'b0}};
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
            acc_r      <= {(2*WIDTH){1'b0}};
            a_sh_r     <= {(2*WIDTH){1'b0}};
            b_sh_r     <= {WIDTH{1'b0}};
            cnt_r      <= {SHW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            acc_r   <= {(2*WIDTH){1'b0}};
                            cnt_r   <= {SHW{1'b0}};
                            a_sh_r  <= {{WIDTH{1'b0}}, a};
                            b_sh_r  <= b;
                            state_r <= ST_MUL;
                        end else begin
                            result_r   <= alu_res_s;
                            zero_r     <= (alu_res_s == {WIDTH{1'b0}});
                            negative_r <= alu_res_s[WIDTH-1];
                            carry_r    <= alu_c_s;
                            overflow_r <= alu_v_s;
                            state_r    <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r  <= acc_next_s;
                    a_sh_r <= {a_sh_r[2*WIDTH-2:0], 1'b0};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    cnt_r  <= cnt_r + 1'b1;
                    // cnt_r all-ones marks the WIDTH-th multiplier bit.
                    if (&cnt_r) begin
                        result_r   <= acc_next_s[WIDTH-1:0];
                        zero_r     <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        negative_r <= acc_next_s[WIDTH-1];
                        carry_r    <= |acc_next_s[2*WIDTH-1:WIDTH];
                        overflow_r <= 1'b0;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=8): a reference model pushes expected
// results at issue time; each scenario task pops and compares when output appears.
module tb_seq_alu;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
    } pkt_t;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero, negative, carry, overflow;

    int   checks = 0;
    int   failures = 0;
    pkt_t sb_q[$];

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic pkt_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [31:0] r;
        int sx, sy, sr, sh;
        pkt_t p;
        sx = $signed(x);
        sy = $signed(y);
        sh = int'(y[2:0]);
        p.c = 1'b0;
        p.v = 1'b0;
        r = 32'd0;
        case (o)
            ADD: begin
                r = 32'(x) + 32'(y);
                p.c = (r > 32'd255);
                sr = sx + sy;
                p.v = (sr > 127) || (sr < -128);
            end
            SUB: begin
                r = 32'(x) - 32'(y);
                p.c = (x < y);
                sr = sx - sy;
                p.v = (sr > 127) || (sr < -128);
            end
            AND_: r = 32'(x & y);
            OR_:  r = 32'(x | y);
            XOR_: r = 32'(x ^ y);
            SHL: begin
                r = 32'(x) << sh;
                p.c = r[8];
            end
            SHR: begin
                r = 32'(x) >> sh;
                p.c = (sh != 0) ? x[sh-1] : 1'b0;
            end
            default: begin
                r = 32'(x) * 32'(y);
                p.c = (r > 32'd255);
            end
        endcase
        p.res = r[7:0];
        p.z = (r[7:0] == 8'h00);
        p.n = r[7];
        return p;
    endfunction

    // Issue one op with out_ready high; returns captured output, edges to out_valid, and whether in_ready rose while busy.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          output pkt_t got, output int lat, output bit rdy_busy);
        rdy_busy = 1'b0;
        lat = 0;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        sb_q.push_back(model(o, x, y));
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            if (!out_valid && in_ready) rdy_busy = 1'b1;
        end while (!out_valid && lat < 40);
        got = {result, zero, negative, carry, overflow};
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        checks++;
        if ({result, zero, negative, carry, overflow} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: result=%h flags=%b%b%b%b, required 00/0000",
                     result, zero, negative, carry, overflow);
        end
    endtask

    task automatic test_single_cycle_ops;
        logic [2:0] ops[11] = '{ADD, ADD, ADD, SUB, SUB, AND_, OR_, XOR_, SHL, SHR, SHR};
        logic [7:0] as[11]  = '{8'hFF, 8'h7F, 8'h80, 8'h80, 8'h03, 8'hF0, 8'h0C, 8'h3C, 8'h81, 8'h01, 8'h01};
        logic [7:0] bs[11]  = '{8'h01, 8'h01, 8'h80, 8'h01, 8'h05, 8'h3C, 8'h30, 8'h0F, 8'h09, 8'h00, 8'h01};
        pkt_t got, exp;
        int lat;
        bit rb;
        for (int i = 0; i < 11; i++) begin
            run_op(ops[i], as[i], bs[i], got, lat, rb);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'h000;
            checks++;
            if (got !== exp || lat != 1) begin
                failures++;
                $display("FAIL op%0d_%h_%h: result/flags=%h latency=%0d, required %h latency=1",
                         ops[i], as[i], bs[i], got, lat, exp);
            end
        end
    endtask

    task automatic test_shift_edges;
        pkt_t got, exp;
        int lat;
        bit rb;
        run_op(SHL, 8'h81, 8'h07, got, lat, rb);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'h000;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL shl_by7: got %h, required %h", got, exp);
        end
        run_op(SHR, 8'hC0, 8'hF7, got, lat, rb);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'h000;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL shr_upper_b_ignored: got %h, required %h", got, exp);
        end
    endtask

    task automatic test_mul;
        logic [7:0] as[4] = '{8'h0F, 8'h10, 8'hFF, 8'h0D};
        logic [7:0] bs[4] = '{8'h11, 8'h10, 8'hFF, 8'h0B};
        pkt_t got, exp;
        int lat;
        bit rb;
        for (int i = 0; i < 4; i++) begin
            run_op(MUL, as[i], bs[i], got, lat, rb);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'h000;
            checks++;
            if (got !== exp || lat != 9 || rb) begin
                failures++;
                $display("FAIL mul_%h_%h: result/flags=%h latency=%0d ready_while_busy=%b, required %h latency=9 ready_while_busy=0",
                         as[i], bs[i], got, lat, rb, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        pkt_t got, exp;
        int lat;
        bit rb;
        for (int i = 0; i < 6; i++) begin
            logic [2:0] o;
            logic [7:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            run_op(o, x, y, got, lat, rb);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'h000;
            checks++;
            if (got !== exp || lat != ((o == MUL) ? 9 : 1)) begin
                failures++;
                $display("FAIL b2b_op%0d_%h_%h: got %h latency=%0d, required %h", o, x, y, got, lat, exp);
            end
        end
    endtask

    task automatic test_backpressure;
        pkt_t got, exp;
        int bad;
        @(negedge clk);
        op = XOR_; a = 8'hAA; b = 8'h55; in_valid = 1'b1; out_ready = 1'b0;
        sb_q.push_back(model(XOR_, 8'hAA, 8'h55));
        @(posedge clk);
        @(negedge clk);
        op = ADD; a = 8'h01; b = 8'h01;
        sb_q.push_back(model(ADD, 8'h01, 8'h01));
        got = {result, zero, negative, carry, overflow};
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {result, zero, negative, carry, overflow} !== got) bad++;
        end
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'h000;
        checks++;
        if (got !== exp || bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold: got %h unstable_cycles=%0d, required %h unstable_cycles=0", got, bad, exp);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        got = {result, zero, negative, carry, overflow};
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'h000;
        checks++;
        if (out_valid !== 1'b1 || got !== exp) begin
            failures++;
            $display("FAIL backpressure_second_op: out_valid=%b got %h, required 1 %h", out_valid, got, exp);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid_mul;
        pkt_t got, exp;
        int lat, seen;
        bit rb;
        @(negedge clk);
        op = MUL; a = 8'h0F; b = 8'h11; in_valid = 1'b1; out_ready = 1'b1;
        sb_q.push_back(model(MUL, 8'h0F, 8'h11));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {result, zero, negative, carry, overflow} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_mul: out_valid=%b in_ready=%b result=%h flags=%b%b%b%b, required 0/1/00/0000",
                     out_valid, in_ready, result, zero, negative, carry, overflow);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_abort: stale out_valid cycles=%0d in_ready=%b, required 0/1", seen, in_ready);
        end
        run_op(ADD, 8'h01, 8'h02, got, lat, rb);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'h000;
        checks++;
        if (got !== exp || got.res !== 8'h03 || lat != 1) begin
            failures++;
            $display("FAIL post_reset_add: got %h latency=%0d, required %h latency=1", got, lat, exp);
        end
    endtask

    initial begin
        test_reset;
        test_single_cycle_ops;
        test_shift_edges;
        test_mul;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_mul;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
